// File: rtl/pll_reconf_seq.sv
// Avalon-MM sequencer that retunes the PLL for PAL or NTSC through the
// reconfig core, then waits for relock or flags a timeout.
module pll_reconf_seq #(
  parameter logic [31:0] PAL_M    = 32'h0000_0404,
  parameter logic [31:0] PAL_C0   = 32'h0000_0606,
  parameter logic [31:0] PAL_K    = 32'h8336_4059,
  parameter logic [31:0] NTSC_M   = 32'h0000_0404,
  parameter logic [31:0] NTSC_C0  = 32'h0000_0707,
  parameter logic [31:0] NTSC_K   = 32'h04A7_904A,
  parameter logic [23:0] LOCK_TMO = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ntsc,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_read,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, WR_MODE, WR_M, WR_C,
    WR_K, WR_START, WAIT_UNLOCK, WAIT_LOCK
  } state_t;

  state_t      state, state_n;
  logic [23:0] cnt, cnt_n;
  logic        ntsc_q, ntsc_q_n;
  logic        cfg_sel, cfg_sel_n;
  logic        locked_meta, locked_s;
  logic [5:0]  addr_n;
  logic [31:0] data_n;
  logic        write_n, busy_n, done_n, err_n;
  logic        accepted;

  assign mgmt_read = 1'b0;
  assign accepted  = mgmt_write && !mgmt_waitrequest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      ntsc_q         <= 1'b0;
      cfg_sel        <= 1'b0;
      locked_meta    <= 1'b0;
      locked_s       <= 1'b0;
      mgmt_address   <= '0;
      mgmt_write     <= 1'b0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      ntsc_q         <= ntsc_q_n;
      cfg_sel        <= cfg_sel_n;
      locked_meta    <= pll_locked;
      locked_s       <= locked_meta;
      mgmt_address   <= addr_n;
      mgmt_write     <= write_n;
      mgmt_writedata <= data_n;
      busy           <= busy_n;
      done           <= done_n;
      err            <= err_n;
    end
  end

  // Each write state holds one write, then spends one cycle with write low
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ntsc_q_n  = ntsc_q;
    cfg_sel_n = cfg_sel;
    addr_n    = mgmt_address;
    data_n    = mgmt_writedata;
    write_n   = mgmt_write;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = err;
    unique case (state)
      IDLE: begin
        if (ntsc != ntsc_q) begin
          state_n   = WR_MODE;
          cfg_sel_n = ntsc;
          ntsc_q_n  = ntsc;
          err_n     = 1'b0;
          busy_n    = 1'b1;
          write_n   = 1'b1;
          addr_n    = 6'd0;
          data_n    = 32'd0;
        end
      end
      WR_MODE: begin
        if (accepted) write_n = 1'b0;
        else if (!mgmt_write) begin
          state_n = WR_M;
          write_n = 1'b1;
          addr_n  = 6'd4;
          data_n  = cfg_sel ? NTSC_M : PAL_M;
        end
      end
      WR_M: begin
        if (accepted) write_n = 1'b0;
        else if (!mgmt_write) begin
          state_n = WR_C;
          write_n = 1'b1;
          addr_n  = 6'd5;
          data_n  = cfg_sel ? NTSC_C0 : PAL_C0;
        end
      end
      WR_C: begin
        if (accepted) write_n = 1'b0;
        else if (!mgmt_write) begin
          state_n = WR_K;
          write_n = 1'b1;
          addr_n  = 6'd7;
          data_n  = cfg_sel ? NTSC_K : PAL_K;
        end
      end
      WR_K: begin
        if (accepted) write_n = 1'b0;
        else if (!mgmt_write) begin
          state_n = WR_START;
          write_n = 1'b1;
          addr_n  = 6'd2;
          data_n  = 32'd0;
        end
      end
      WR_START: begin
        if (accepted) begin
          write_n = 1'b0;
          state_n = WAIT_UNLOCK;
          cnt_n   = '0;
        end
      end
      WAIT_UNLOCK: begin
        if (!locked_s || cnt[3:0] == 4'hF) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cnt == LOCK_TMO - 24'd1) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Scoreboard bench for pll_reconf_seq: expected Avalon writes are queued by
// the stimulus and popped by a monitor on every accepted write.
module tb_pll_reconf_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ntsc;
  logic        pll_locked;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_read;
  logic        mgmt_waitrequest;
  logic        busy, done, err;

  always #5 clk = ~clk;

  pll_reconf_seq #(.LOCK_TMO(24'd1000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ntsc(ntsc),
    .pll_locked(pll_locked),
    .mgmt_address(mgmt_address),
    .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata),
    .mgmt_read(mgmt_read),
    .mgmt_waitrequest(mgmt_waitrequest),
    .busy(busy),
    .done(done),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int wr_cnt = 0;
  int ncyc = 0;
  int start_t = 0;
  int t0 = 0;
  logic [37:0] exp_q[$];
  bit stall_mode = 0;
  bit stall_hold = 0;
  bit hold_unlock = 0;
  event start_ev;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_seq(bit nt, int n = 5);
    logic [37:0] s[5];
    s[0] = {6'd0, 32'd0};
    s[1] = {6'd4, 32'h0000_0404};
    s[2] = {6'd5, nt ? 32'h0000_0707 : 32'h0000_0606};
    s[3] = {6'd7, nt ? 32'h04A7_904A : 32'h8336_4059};
    s[4] = {6'd2, 32'd0};
    for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
  endtask

  task automatic wait_done(int n, int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    chk("done_count", done_cnt, n);
  endtask

  task automatic wait_addr(logic [5:0] a, int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (mgmt_write && mgmt_address == a) found = 1;
    end
    chk("reach_addr", found, 1);
  endtask

  // Responder and scoreboard monitor
  initial begin
    logic [37:0] held, e;
    bit stalled = 0;
    int stall_cnt = 0;
    mgmt_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (done) done_cnt++;
      if (!rst_n) begin
        stalled = 0;
        stall_cnt = 0;
        mgmt_waitrequest = 1'b0;
      end else if (mgmt_write) begin
        if (stalled)
          chk("stall_stable", {mgmt_address, mgmt_writedata}, held);
        if ((stall_hold && mgmt_address == 6'd7) ||
            (stall_mode && stall_cnt < 3)) begin
          mgmt_waitrequest = 1'b1;
          stall_cnt++;
          stalled = 1;
          held = {mgmt_address, mgmt_writedata};
        end else begin
          mgmt_waitrequest = 1'b0;
          stalled = 0;
          stall_cnt = 0;
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %0h/%0h expected none",
                     mgmt_address, mgmt_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("write", {mgmt_address, mgmt_writedata}, e);
          end
          chk("read_low", mgmt_read, 0);
          if (mgmt_address == 6'd2) begin
            start_cnt++;
            start_t = ncyc;
            ->start_ev;
          end
        end
      end else begin
        if (stalled) chk("write_dropped", mgmt_write, 1);
        stalled = 0;
        mgmt_waitrequest = 1'b0;
      end
    end
  end

  // PLL model: loses lock on START, relocks 50 cycles later
  initial begin
    pll_locked = 1'b1;
    forever begin
      @(start_ev);
      pll_locked = 1'b0;
      if (!hold_unlock) begin
        repeat (50) @(negedge clk);
        pll_locked = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst_n = 1'b0;
    ntsc  = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with PAL selected
    repeat (100) @(negedge clk);
    chk("t1_writes", wr_cnt, 0);
    chk("t1_busy", busy, 0);
    chk("t1_err", err, 0);
    chk("t1_done", done_cnt, 0);
    chk("t1_read", mgmt_read, 0);

    // PAL -> NTSC, no stalls
    push_seq(1);
    @(negedge clk);
    ntsc = 1'b1;
    #1 t0 = ncyc;
    wait_done(1, 400);
    chk("t2_latency", start_t - t0, 9);
    @(negedge clk);
    chk("t2_busy", busy, 0);
    chk("t2_err", err, 0);
    chk("t2_queue", exp_q.size(), 0);

    // NTSC -> PAL with 3-cycle waitrequest on every write
    stall_mode = 1;
    push_seq(0);
    @(negedge clk);
    ntsc = 1'b0;
    wait_done(2, 600);
    stall_mode = 0;
    chk("t3_queue", exp_q.size(), 0);

    // Relock timeout
    hold_unlock = 1;
    push_seq(1);
    @(negedge clk);
    ntsc = 1'b1;
    for (i = 0; i < 200 && start_cnt < 3; i++) @(negedge clk);
    chk("t4_start", start_cnt, 3);
    repeat (990) @(negedge clk);
    chk("t4_err_early", err, 0);
    for (i = 0; i < 60 && !err; i++) @(negedge clk);
    chk("t4_err", err, 1);
    chk("t4_no_done", done_cnt, 2);
    @(negedge clk);
    chk("t4_busy", busy, 0);

    // Next toggle clears err
    hold_unlock = 0;
    pll_locked = 1'b1;
    push_seq(0);
    ntsc = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err_clr", err, 0);
    chk("t4_busy_set", busy, 1);
    wait_done(3, 400);

    // Toggles during WR_C ending on a new value
    push_seq(1);
    @(negedge clk);
    ntsc = 1'b1;
    wait_done(4, 400);
    push_seq(0);
    push_seq(1);
    @(negedge clk);
    ntsc = 1'b0;
    wait_addr(6'd5, 50);
    ntsc = 1'b1;
    @(negedge clk);
    ntsc = 1'b0;
    @(negedge clk);
    ntsc = 1'b1;
    wait_done(6, 800);
    chk("t5a_queue", exp_q.size(), 0);

    // Toggles ending on the original value
    push_seq(0);
    @(negedge clk);
    ntsc = 1'b0;
    wait_addr(6'd5, 50);
    ntsc = 1'b1;
    @(negedge clk);
    ntsc = 1'b0;
    wait_done(7, 400);
    repeat (100) @(negedge clk);
    chk("t5b_done", done_cnt, 7);
    chk("t5b_queue", exp_q.size(), 0);
    chk("t5b_busy", busy, 0);

    // Reset while WR_K is stalled
    push_seq(1, 3);
    stall_hold = 1;
    @(negedge clk);
    ntsc = 1'b1;
    wait_addr(6'd7, 50);
    @(negedge clk);
    #1 rst_n = 1'b0;
    stall_hold = 0;
    #1;
    chk("t6_write", mgmt_write, 0);
    chk("t6_busy", busy, 0);
    chk("t6_queue", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    push_seq(1);
    rst_n = 1'b1;
    wait_done(8, 400);
    chk("t6_queue_end", exp_q.size(), 0);
    chk("t6_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
